lcd_time_display: RTL and testbench
===================================

# lcd_time_display

Converts the recorder's two 16-bit BCD timers (record time, play time, each {min_1, min_0, sec_1, sec_0}) into character writes for the DE2-115 16x2 character LCD. Sits directly downstream of the recorder timing core and upstream of the LCD character driver, issuing one character per valid/ready handshake. Rewrites only a timer field whose value has changed since it was last written.

## Interface
- No parameters.
- i_clk  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_record_time  in  16  BCD record time {m1,m0,s1,s0}
- i_play_time  in  16  BCD play time {m1,m0,s1,s0}
- o_char_valid  out  1  character write request
- o_char_addr  out  5  LCD cell: 0-15 row 0, 16-31 row 1
- i_char_ready  in  1  driver accepts the character on this edge when valid
- o_char_data  out  8  ASCII code
- o_busy  out  1  high whenever state != IDLE

## Operation
- Inputs are registered once (r_rec, r_play); all decisions use the registered copies.
- Shadow registers sh_rec and sh_play hold the last fully written values. Flags dirty_rec and dirty_play are set by reset.
- Field layout:
  - Record field: digits at addresses 5, 6, ':' at 7, digits at 8, 9.
  - Play field: digits at 21, 22, ':' at 23, digits at 24, 25.
- Digit encoding: 8'h30 + nibble. A nibble > 9 is written as '?' (8'h3F).
- States:
  - IDLE: if dirty_rec or r_rec != sh_rec, go to REC_WR and snapshot r_rec. Otherwise, if dirty_play or r_play != sh_play, go to PLAY_WR and snapshot r_play. Record has priority when both differ.
  - REC_WR / PLAY_WR: emit 5 characters in address order from the snapshot. After the 5th acceptance, copy the snapshot into the shadow, clear the dirty flag, and return to IDLE.
  - LABEL (only with macro): see Configuration.
- An input change during a write does not alter the characters in flight. It is detected from IDLE after the sequence completes.
- If record keeps changing, play is still served: after REC_WR, IDLE checks play before record on the next decision (round-robin).

## Timing
- Reset values: o_char_valid=0, o_char_addr=0, o_char_data=8'h20, o_busy=0, state=IDLE, shadows=16'h0000, dirty flags=1.
- The first decision happens in the first cycle after reset release, so o_busy and o_char_valid go high 1 cycle after release.
- Handshake:
  - Valid, addr and data are registered and held stable while valid && !ready.
  - A transfer completes on an edge where valid && ready.
  - The next character is presented in the cycle after that edge. With ready tied high, 5 characters take 5 consecutive cycles.
  - Valid never drops without a completed transfer, except on reset.
- Latency: a new input value presented at edge k, with the block in IDLE, produces o_char_valid high from edge k+2.
- Reset mid-sequence: valid is cleared immediately (async). The partial field is repainted because the dirty flags are set again.
- Snapshot equal to shadow (a value changed and then reverted before IDLE sampled it): no write occurs.

## Configuration
- LCD_TIME_LABEL_EN defined:
  - After reset, a LABEL state precedes all timer writes.
  - It writes "REC" to addresses 0-2 and "PLAY" to addresses 16-19, 7 characters in that order, once per reset.
  - o_busy is high throughout. The first timer write follows immediately.
- LCD_TIME_LABEL_EN undefined:
  - The LABEL state and its counter are absent.
  - Only addresses 5-9 and 21-25 are ever written.

## Test plan
- Reset release, ready=1, inputs 16'h0000, macro off -> 10 writes: addr 5,6,7,8,9 data 30,30,3A,30,30, then addr 21-25 data 30,30,3A,30,30. Then o_busy=0 and valid stays 0.
- Macro on, same as above -> 7 label writes ("REC" to 0-2, "PLAY" to 16-19) precede the 10 timer writes.
- From idle, i_record_time 16'h0000 -> 16'h0109 -> valid at edge k+2, writes 30,31,3A,30,39 to addr 5-9. No play writes.
- Ready held low 4 cycles on the 2nd character -> addr/data held stable, valid stays 1, no character skipped or duplicated.
- Both inputs change in the same cycle (rec 16'h0012, play 16'h0007) -> record field written first, then play field 30,30,3A,30,37.
- Play nibble 4'hA (16'h00A0) -> addr 24 written 3F. Reset asserted mid-field -> valid=0 at once, and a full repaint follows release.

Source files
------------

// File: rtl/lcd_time_display.sv
// -----------------------------------------------------------------------------
// lcd_time_display
//
// Turns the recorder's two BCD timers (record time, play time, each
// {min_1, min_0, sec_1, sec_0}) into single-character writes for the 16x2
// character LCD driver, one character per valid/ready handshake. A timer field
// is rewritten only when its value differs from what was last fully written
// (or after reset, when both fields are marked dirty).
//
// Screen layout
//    record field : "mm:ss" at cells  5..9  (row 0)
//    play field   : "mm:ss" at cells 21..25 (row 1)
//
// Optional feature (compile-time macro LCD_TIME_LABEL_EN)
//    When defined, a LABEL sequence after every reset writes "REC" to cells
//    0..2 and "PLAY" to cells 16..19 before the first timer write. When
//    undefined, the LABEL state and its counter do not exist.
//
// Ports
//    i_clk          in   1   system clock (50 MHz)
//    i_rst_n        in   1   asynchronous active-low reset
//    i_record_time  in  16   BCD record time {m1,m0,s1,s0}
//    i_play_time    in  16   BCD play time   {m1,m0,s1,s0}
//    o_char_valid   out  1   character write request (registered)
//    o_char_addr    out  5   LCD cell: 0-15 row 0, 16-31 row 1 (registered)
//    i_char_ready   in   1   driver accepts the character on an edge with valid
//    o_char_data    out  8   ASCII code (registered)
//    o_busy         out  1   high whenever the sequencer is not IDLE (registered)
// -----------------------------------------------------------------------------
module lcd_time_display (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_record_time,
   input  logic [15:0] i_play_time,
   output logic        o_char_valid,
   output logic [4:0]  o_char_addr,
   input  logic        i_char_ready,
   output logic [7:0]  o_char_data,
   output logic        o_busy
);

`ifdef LCD_TIME_LABEL_EN
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REC_WR  = 2'd1,
      PLAY_WR = 2'd2,
      LABEL   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REC_WR  = 2'd1,
      PLAY_WR = 2'd2
   } state_t;
`endif

   // ---------------------------------------------------------------------
   // Character helpers
   // ---------------------------------------------------------------------

   // One BCD nibble as ASCII; anything that is not a decimal digit shows '?'.
   function automatic logic [7:0] digit_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib > 4'd9) begin
         c = 8'h3F;
      end else begin
         c = 8'h30 + {4'h0, nib};
      end
      return c;
   endfunction

   // Character idx (0..4) of the "mm:ss" rendering of a timer value.
   function automatic logic [7:0] field_char(input logic [15:0] t, input logic [2:0] idx);
      logic [7:0] c;
      case (idx)
         3'd0:    c = digit_char(t[15:12]);
         3'd1:    c = digit_char(t[11:8]);
         3'd2:    c = 8'h3A;
         3'd3:    c = digit_char(t[7:4]);
         3'd4:    c = digit_char(t[3:0]);
         default: c = 8'h20;
      endcase
      return c;
   endfunction

   // LCD cell of character idx within the record (row 0) or play (row 1) field.
   function automatic logic [4:0] field_addr(input logic is_play, input logic [2:0] idx);
      logic [4:0] base;
      if (is_play) begin
         base = 5'd21;
      end else begin
         base = 5'd5;
      end
      return base + {2'b00, idx};
   endfunction

`ifdef LCD_TIME_LABEL_EN
   // {addr, data} of label character idx: "REC" at 0..2, then "PLAY" at 16..19.
   function automatic logic [12:0] label_char(input logic [2:0] idx);
      logic [12:0] ad;
      case (idx)
         3'd0:    ad = {5'd0,  8'h52};   // R
         3'd1:    ad = {5'd1,  8'h45};   // E
         3'd2:    ad = {5'd2,  8'h43};   // C
         3'd3:    ad = {5'd16, 8'h50};   // P
         3'd4:    ad = {5'd17, 8'h4C};   // L
         3'd5:    ad = {5'd18, 8'h41};   // A
         3'd6:    ad = {5'd19, 8'h59};   // Y
         default: ad = {5'd0,  8'h20};
      endcase
      return ad;
   endfunction
`endif

   // ---------------------------------------------------------------------
   // Registers and control signals
   // ---------------------------------------------------------------------
   state_t      state_r;
   state_t      state_next_s;

   logic [15:0] rec_in_r;
   logic [15:0] play_in_r;
   logic [15:0] sh_rec_r;
   logic [15:0] sh_play_r;
   logic        dirty_rec_r;
   logic        dirty_play_r;
   logic [15:0] snap_r;
   logic [2:0]  idx_r;
   logic        rr_play_r;      // set right after a record field: play wins the next decision

`ifdef LCD_TIME_LABEL_EN
   logic        label_pend_r;
   logic [2:0]  lbl_idx_r;
   logic        lbl_last_s;
`endif

   logic        want_rec_s;
   logic        want_play_s;
   logic        pick_play_s;
   logic        accept_s;
   logic        last_s;

   logic        valid_next_s;
   logic [4:0]  addr_next_s;
   logic [7:0]  data_next_s;

   assign want_rec_s  = dirty_rec_r  || (rec_in_r  != sh_rec_r);
   assign want_play_s = dirty_play_r || (play_in_r != sh_play_r);
   // Record normally has priority; right after a record field play goes first
   // so a constantly changing record time cannot starve the play field.
   assign pick_play_s = want_play_s && (rr_play_r || !want_rec_s);
   assign accept_s    = o_char_valid && i_char_ready;
   assign last_s      = accept_s && (idx_r == 3'd4);
`ifdef LCD_TIME_LABEL_EN
   assign lbl_last_s  = accept_s && (lbl_idx_r == 3'd6);
`endif

   // ---------------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------------

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // ---------------------------------------------------------------------
   // FSM process 2: next-state logic
   // ---------------------------------------------------------------------

   // Next-state decision.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
`ifdef LCD_TIME_LABEL_EN
            if (label_pend_r) begin
               state_next_s = LABEL;
            end else
`endif
            if (pick_play_s) begin
               state_next_s = PLAY_WR;
            end else if (want_rec_s) begin
               state_next_s = REC_WR;
            end else begin
               state_next_s = IDLE;
            end
         end
         REC_WR, PLAY_WR: begin
            if (last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
`ifdef LCD_TIME_LABEL_EN
         LABEL: begin
            // The record field is still dirty, so go straight into it.
            if (lbl_last_s) begin
               state_next_s = REC_WR;
            end else begin
               state_next_s = LABEL;
            end
         end
`endif
         default: state_next_s = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM process 3: output logic (next values of the registered outputs)
   // ---------------------------------------------------------------------

   // Next character request; holds addr/data while a request waits for ready.
   always_comb begin
      valid_next_s = o_char_valid;
      addr_next_s  = o_char_addr;
      data_next_s  = o_char_data;
      case (state_r)
         IDLE: begin
            // The first character comes from the value being snapshotted now.
            if (state_next_s == REC_WR) begin
               valid_next_s = 1'b1;
               addr_next_s  = field_addr(1'b0, 3'd0);
               data_next_s  = field_char(rec_in_r, 3'd0);
            end else if (state_next_s == PLAY_WR) begin
               valid_next_s = 1'b1;
               addr_next_s  = field_addr(1'b1, 3'd0);
               data_next_s  = field_char(play_in_r, 3'd0);
            end
`ifdef LCD_TIME_LABEL_EN
            else if (state_next_s == LABEL) begin
               valid_next_s = 1'b1;
               {addr_next_s, data_next_s} = label_char(3'd0);
            end
`endif
            else begin
               valid_next_s = 1'b0;
            end
         end
         REC_WR, PLAY_WR: begin
            if (last_s) begin
               valid_next_s = 1'b0;
            end else if (accept_s) begin
               valid_next_s = 1'b1;
               addr_next_s  = field_addr(state_r == PLAY_WR, idx_r + 3'd1);
               data_next_s  = field_char(snap_r, idx_r + 3'd1);
            end else begin
               valid_next_s = o_char_valid;
            end
         end
`ifdef LCD_TIME_LABEL_EN
         LABEL: begin
            if (lbl_last_s) begin
               valid_next_s = 1'b1;
               addr_next_s  = field_addr(1'b0, 3'd0);
               data_next_s  = field_char(rec_in_r, 3'd0);
            end else if (accept_s) begin
               valid_next_s = 1'b1;
               {addr_next_s, data_next_s} = label_char(lbl_idx_r + 3'd1);
            end else begin
               valid_next_s = o_char_valid;
            end
         end
`endif
         default: begin
            valid_next_s = 1'b0;
         end
      endcase
   end

   // Registered LCD request outputs and busy flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_char_valid <= 1'b0;
         o_char_addr  <= 5'd0;
         o_char_data  <= 8'h20;
         o_busy       <= 1'b0;
      end else begin
         o_char_valid <= valid_next_s;
         o_char_addr  <= addr_next_s;
         o_char_data  <= data_next_s;
         o_busy       <= (state_next_s != IDLE);
      end
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------

   // Input capture. Left out of reset on purpose: it keeps tracking the timers
   // while reset is held, so the repaint after release shows the live values.
   always_ff @(posedge i_clk) begin
      rec_in_r  <= i_record_time;
      play_in_r <= i_play_time;
   end

   // Snapshot, character index, shadows, dirty flags and arbitration state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_rec_r     <= 16'h0000;
         sh_play_r    <= 16'h0000;
         dirty_rec_r  <= 1'b1;
         dirty_play_r <= 1'b1;
         snap_r       <= 16'h0000;
         idx_r        <= 3'd0;
         rr_play_r    <= 1'b0;
`ifdef LCD_TIME_LABEL_EN
         label_pend_r <= 1'b1;
         lbl_idx_r    <= 3'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               idx_r     <= 3'd0;
               rr_play_r <= 1'b0;
               if (state_next_s == REC_WR) begin
                  snap_r <= rec_in_r;
               end else if (state_next_s == PLAY_WR) begin
                  snap_r <= play_in_r;
               end else begin
                  snap_r <= snap_r;
               end
            end
            REC_WR: begin
               if (last_s) begin
                  sh_rec_r    <= snap_r;
                  dirty_rec_r <= 1'b0;
                  rr_play_r   <= 1'b1;
                  idx_r       <= 3'd0;
               end else if (accept_s) begin
                  idx_r <= idx_r + 3'd1;
               end else begin
                  idx_r <= idx_r;
               end
            end
            PLAY_WR: begin
               if (last_s) begin
                  sh_play_r    <= snap_r;
                  dirty_play_r <= 1'b0;
                  idx_r        <= 3'd0;
               end else if (accept_s) begin
                  idx_r <= idx_r + 3'd1;
               end else begin
                  idx_r <= idx_r;
               end
            end
`ifdef LCD_TIME_LABEL_EN
            LABEL: begin
               if (lbl_last_s) begin
                  label_pend_r <= 1'b0;
                  lbl_idx_r    <= 3'd0;
                  snap_r       <= rec_in_r;
                  idx_r        <= 3'd0;
               end else if (accept_s) begin
                  lbl_idx_r <= lbl_idx_r + 3'd1;
               end else begin
                  lbl_idx_r <= lbl_idx_r;
               end
            end
`endif
            default: begin
               idx_r <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_time_display.sv
// -----------------------------------------------------------------------------
// tb_lcd_time_display
//
// Directed bench for lcd_time_display. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on rising edges. Expected characters
// are written out by hand as "mm:ss" ASCII for each timer value.
// -----------------------------------------------------------------------------
module tb_lcd_time_display;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [15:0] i_record_time;
   logic [15:0] i_play_time;
   logic        o_char_valid;
   logic [4:0]  o_char_addr;
   logic        i_char_ready;
   logic [7:0]  o_char_data;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   lcd_time_display dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_record_time (i_record_time),
      .i_play_time   (i_play_time),
      .o_char_valid  (o_char_valid),
      .o_char_addr   (o_char_addr),
      .i_char_ready  (i_char_ready),
      .o_char_data   (o_char_data),
      .o_busy        (o_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a request, check it, and let it be accepted (ready=1).
   task automatic expect_char(input string tag, input logic [4:0] ea, input logic [7:0] ed,
                              input int max_wait);
      int n;
      n = 0;
      while (o_char_valid !== 1'b1 && n <= max_wait) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_wait"}, (n <= max_wait) ? 32'd1 : 32'd0, 32'd1);
      check({tag, "_addr"}, {27'd0, o_char_addr}, {27'd0, ea});
      check({tag, "_data"}, {24'd0, o_char_data}, {24'd0, ed});
      @(negedge i_clk);
   endtask

   // Five characters of one field, back to back after the first.
   task automatic expect_field(input string tag, input logic [4:0] base, input logic [39:0] chars,
                               input int first_wait);
      logic [4:0] a;
      for (int i = 0; i < 5; i++) begin
         a = base + 5'(i);
         expect_char($sformatf("%s%0d", tag, i), a, chars[39-8*i -: 8], (i == 0) ? first_wait : 0);
      end
   endtask

   task automatic expect_labels();
`ifdef LCD_TIME_LABEL_EN
      expect_char("lbl_r", 5'd0,  8'h52, 3);
      expect_char("lbl_e", 5'd1,  8'h45, 0);
      expect_char("lbl_c", 5'd2,  8'h43, 0);
      expect_char("lbl_p", 5'd16, 8'h50, 0);
      expect_char("lbl_l", 5'd17, 8'h4C, 0);
      expect_char("lbl_a", 5'd18, 8'h41, 0);
      expect_char("lbl_y", 5'd19, 8'h59, 0);
`endif
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check($sformatf("%s_valid%0d", tag, i), {31'd0, o_char_valid}, 32'd0);
         @(negedge i_clk);
      end
   endtask

   initial begin
      i_rst_n       = 1'b0;
      i_record_time = 16'h0000;
      i_play_time   = 16'h0000;
      i_char_ready  = 1'b1;

      // Reset values
      repeat (2) @(negedge i_clk);
      check("rst_valid", {31'd0, o_char_valid}, 32'd0);
      check("rst_addr",  {27'd0, o_char_addr},  32'd0);
      check("rst_data",  {24'd0, o_char_data},  32'h20);
      check("rst_busy",  {31'd0, o_busy},       32'd0);

      // Release: busy and valid one cycle later, then the full paint
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rel_busy",  {31'd0, o_busy},       32'd1);
      check("rel_valid", {31'd0, o_char_valid}, 32'd1);
      expect_labels();
      expect_field("init_rec",  5'd5,  {8'h30, 8'h30, 8'h3A, 8'h30, 8'h30}, 3);
      expect_field("init_play", 5'd21, {8'h30, 8'h30, 8'h3A, 8'h30, 8'h30}, 1);
      check("init_busy", {31'd0, o_busy}, 32'd0);
      expect_quiet("init_quiet", 5);

      // Latency: value changes just after edge k, valid from edge k+2
      i_record_time = 16'h0109;
      @(negedge i_clk);
      check("lat_k1_valid", {31'd0, o_char_valid}, 32'd0);
      @(negedge i_clk);
      check("lat_k2_valid", {31'd0, o_char_valid}, 32'd1);
      expect_field("lat_rec", 5'd5, {8'h30, 8'h31, 8'h3A, 8'h30, 8'h39}, 0);
      expect_quiet("lat_noplay", 6);

      // Ready held low for 4 cycles on the 2nd character
      i_record_time = 16'h0234;
      expect_char("stall_c0", 5'd5, 8'h30, 3);
      i_char_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         check($sformatf("stall_hold_valid%0d", i), {31'd0, o_char_valid}, 32'd1);
         check($sformatf("stall_hold_addr%0d", i),  {27'd0, o_char_addr},  32'd6);
         check($sformatf("stall_hold_data%0d", i),  {24'd0, o_char_data},  32'h32);
      end
      i_char_ready = 1'b1;
      expect_char("stall_c1", 5'd6, 8'h32, 0);
      expect_char("stall_c2", 5'd7, 8'h3A, 0);
      expect_char("stall_c3", 5'd8, 8'h33, 0);
      expect_char("stall_c4", 5'd9, 8'h34, 0);
      expect_quiet("stall_quiet", 3);

      // Both change together: record field first, then play
      i_record_time = 16'h0012;
      i_play_time   = 16'h0007;
      expect_field("both_rec",  5'd5,  {8'h30, 8'h30, 8'h3A, 8'h31, 8'h32}, 3);
      expect_field("both_play", 5'd21, {8'h30, 8'h30, 8'h3A, 8'h30, 8'h37}, 1);
      expect_quiet("both_quiet", 3);

      // Non-decimal nibble shows '?'
      i_play_time = 16'h00A0;
      expect_field("nib_play", 5'd21, {8'h30, 8'h30, 8'h3A, 8'h3F, 8'h30}, 3);
      expect_quiet("nib_quiet", 3);

      // Reset in the middle of a field, then full repaint
      i_record_time = 16'h0555;
      expect_char("mid_c0", 5'd5, 8'h30, 3);
      expect_char("mid_c1", 5'd6, 8'h35, 0);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, o_char_valid}, 32'd0);
      check("mid_rst_busy",  {31'd0, o_busy},       32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      expect_labels();
      expect_field("rep_rec",  5'd5,  {8'h30, 8'h35, 8'h3A, 8'h35, 8'h35}, 3);
      expect_field("rep_play", 5'd21, {8'h30, 8'h30, 8'h3A, 8'h3F, 8'h30}, 1);
      expect_quiet("rep_quiet", 3);

      // Record glitches and reverts while busy with play: no record write
      i_play_time = 16'h0011;
      expect_char("rev_p0", 5'd21, 8'h30, 3);
      i_record_time = 16'h0999;
      expect_char("rev_p1", 5'd22, 8'h30, 0);
      i_record_time = 16'h0555;
      expect_char("rev_p2", 5'd23, 8'h3A, 0);
      expect_char("rev_p3", 5'd24, 8'h31, 0);
      expect_char("rev_p4", 5'd25, 8'h31, 0);
      expect_quiet("rev_quiet", 6);
      check("rev_busy", {31'd0, o_busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
